// File: rtl/canvas_engine.sv
// Paint/clear/stream engine over a WIDTH x HEIGHT canvas; one cell write per cycle, 1-cycle display read.
// Stream holds Out_data/Out_last while Out_ready is low; requests arriving while Busy are dropped (Overrun).
module canvas_engine #(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int PIX_W     = 8,
  parameter int BRUSH_MAX = 3,
  parameter int POS_W     = 10,
  localparam int BW       = $clog2(BRUSH_MAX + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Frame_tick,
  input  logic             Draw,
  input  logic             Erase,
  input  logic             Clear,
  input  logic [POS_W-1:0] X_Pos,
  input  logic [POS_W-1:0] Y_Pos,
  input  logic [BW-1:0]    Brush,
  input  logic [PIX_W-1:0] Intensity,
  input  logic             Start,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [PIX_W-1:0] Out_data,
  output logic             Out_last,
  input  logic [POS_W-1:0] Rd_x,
  input  logic [POS_W-1:0] Rd_y,
  output logic [PIX_W-1:0] Rd_data,
  output logic             Busy,
  output logic             Overrun
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = $clog2(N);
  localparam logic signed [POS_W:0] WIDTH_S  = (POS_W+1)'(WIDTH);
  localparam logic signed [POS_W:0] HEIGHT_S = (POS_W+1)'(HEIGHT);
  localparam logic [POS_W-1:0]      WIDTH_U  = POS_W'(WIDTH);
  localparam logic [POS_W-1:0]      HEIGHT_U = POS_W'(HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PAINT, S_STREAM} state_t;

  state_t state, state_nxt;

  logic [PIX_W-1:0] canvas [N];
  logic [AW-1:0]    idx;
  logic [POS_W-1:0] lat_x, lat_y;
  logic [BW-1:0]    lat_r;
  logic [PIX_W-1:0] lat_inten;
  logic             lat_erase;
  logic [POS_W:0]   dx, dy, span;
  logic signed [POS_W:0] pcol, prow, r_s;
  logic [AW-1:0]    paint_addr, rd_addr, wr_addr;
  logic [PIX_W-1:0] wr_dat;
  logic [PIX_W:0]   sum;
  logic             paint_req, paint_in_range, paint_done, idx_last, beat, drop, wr_en, rd_in_range;

  assign paint_req  = Frame_tick & (Draw | Erase);
  assign idx_last   = (idx == AW'(N - 1));
  assign beat       = (state == S_STREAM) & Out_ready;
  assign span       = (POS_W+1)'({lat_r, 1'b0});
  assign paint_done = (dx == span) && (dy == span);

  // Window coordinates are signed so that cells left of / above the canvas are recognised and skipped.
  assign r_s  = $signed((POS_W+1)'(lat_r));
  assign pcol = $signed({1'b0, lat_x}) - r_s + $signed(dx);
  assign prow = $signed({1'b0, lat_y}) - r_s + $signed(dy);
  assign paint_in_range = !pcol[POS_W] && (pcol < WIDTH_S) && !prow[POS_W] && (prow < HEIGHT_S);
  assign paint_addr = AW'(prow) * AW'(WIDTH) + AW'(pcol);

  assign rd_in_range = (Rd_x < WIDTH_U) && (Rd_y < HEIGHT_U);
  assign rd_addr     = AW'(Rd_y) * AW'(WIDTH) + AW'(Rd_x);

  // In IDLE only the winning request survives; any request while busy is lost.
  assign drop = (state == S_IDLE) ? ((Clear & (Start | paint_req)) | (Start & paint_req))
                                  : (Clear | Start | paint_req);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Clear)          state_nxt = S_CLEAR;
        else if (Start)     state_nxt = S_STREAM;
        else if (paint_req) state_nxt = S_PAINT;
      end
      S_CLEAR:  if (idx_last)         state_nxt = S_IDLE;
      S_PAINT:  if (paint_done)       state_nxt = S_IDLE;
      S_STREAM: if (beat && idx_last) state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Out_valid = (state == S_STREAM);
    Out_last  = (state == S_STREAM) && idx_last;
    Out_data  = canvas[idx];
    wr_en     = 1'b0;
    wr_addr   = idx;
    wr_dat    = '0;
    sum       = {1'b0, canvas[paint_addr]} + {1'b0, lat_inten};
    case (state)
      S_CLEAR: wr_en = 1'b1;
      S_PAINT: begin
        wr_en   = paint_in_range;
        wr_addr = paint_addr;
        if (!lat_erase) wr_dat = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx       <= '0;
      dx        <= '0;
      dy        <= '0;
      lat_x     <= '0;
      lat_y     <= '0;
      lat_r     <= '0;
      lat_inten <= '0;
      lat_erase <= 1'b0;
      Busy      <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      Busy    <= (state_nxt != S_IDLE);
      Overrun <= Overrun | drop;
      case (state)
        S_IDLE: begin
          idx <= '0;
          dx  <= '0;
          dy  <= '0;
          if (state_nxt == S_PAINT) begin
            lat_x     <= X_Pos;
            lat_y     <= Y_Pos;
            lat_r     <= (Brush > BW'(BRUSH_MAX)) ? BW'(BRUSH_MAX) : Brush;
            lat_inten <= Intensity;
            lat_erase <= Erase;
          end
        end
        S_CLEAR: idx <= idx + 1'b1;
        S_PAINT: begin
          if (dx == span) begin
            dx <= '0;
            dy <= dy + 1'b1;
          end else begin
            dx <= dx + 1'b1;
          end
        end
        S_STREAM: if (beat) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N; i++) canvas[i] <= '0;
    end else if (wr_en) begin
      canvas[wr_addr] <= wr_dat;
    end
  end

  // Registered read sees the array before any write landing on the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         Rd_data <= '0;
    else if (rd_in_range) Rd_data <= canvas[rd_addr];
    else                  Rd_data <= '0;
  end

endmodule

// File: tb/tb_canvas_engine.sv
// Directed bench for canvas_engine: paint, saturation, edge clipping, stalled stream, clear/overrun, reset abort.
module tb_canvas_engine;
  localparam int W = 28, H = 28, N = W * H, PW = 8, PSW = 10;

  logic          Clk = 1'b0, Reset_n = 1'b0;
  logic          Frame_tick = 0, Draw = 0, Erase = 0, Clear = 0, Start = 0, Out_ready = 0;
  logic [PSW-1:0] X_Pos = '0, Y_Pos = '0, Rd_x = '0, Rd_y = '0;
  logic [1:0]    Brush = '0;
  logic [PW-1:0] Intensity = '0;
  logic          Out_valid, Out_last, Busy, Overrun;
  logic [PW-1:0] Out_data, Rd_data;

  logic [PW-1:0] model [N];
  int n_vec = 0, n_err = 0;
  int bc, beats, derr, herr, lerr, verr, cyc;

  canvas_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .Frame_tick(Frame_tick), .Draw(Draw), .Erase(Erase),
    .Clear(Clear), .X_Pos(X_Pos), .Y_Pos(Y_Pos), .Brush(Brush), .Intensity(Intensity),
    .Start(Start), .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_data(Out_data),
    .Out_last(Out_last), .Rd_x(Rd_x), .Rd_y(Rd_y), .Rd_data(Rd_data), .Busy(Busy),
    .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_cell(input string tag, input int x, input int y);
    Rd_x = PSW'(x);
    Rd_y = PSW'(y);
    tick();
    chk(tag, 32'(Rd_data), 32'(model[y * W + x]));
  endtask

  // Issues one paint request, returns the number of cycles Busy stayed high, and updates the model.
  task automatic paint(input int x, input int y, input int b, input int inten, input bit er,
                       output int busy_cyc);
    Frame_tick = 1; Draw = !er; Erase = er;
    X_Pos = PSW'(x); Y_Pos = PSW'(y); Brush = 2'(b); Intensity = PW'(inten);
    tick();
    Frame_tick = 0; Draw = 0; Erase = 0;
    busy_cyc = 0;
    while (Busy === 1'b1 && busy_cyc < 2000) begin
      busy_cyc++;
      tick();
    end
    for (int r = y - b; r <= y + b; r++)
      for (int c = x - b; c <= x + b; c++)
        if (r >= 0 && r < H && c >= 0 && c < W) begin
          if (er) model[r * W + c] = '0;
          else if (int'(model[r * W + c]) + inten > 255) model[r * W + c] = 8'd255;
          else model[r * W + c] = PW'(int'(model[r * W + c]) + inten);
        end
  endtask

  // Streams the canvas; stall_mode applies the ready pattern 1,0,0,1. Stops after stop_at beats.
  task automatic stream(input bit stall_mode, input int stop_at);
    logic [PW-1:0] prev_d;
    logic prev_l;
    bit prev_stall, rdy;
    Start = 1;
    tick();
    Start = 0;
    beats = 0; derr = 0; herr = 0; lerr = 0; verr = 0; cyc = 0; prev_stall = 0;
    prev_d = '0; prev_l = 0;
    while (beats < stop_at && cyc < 8000) begin
      rdy = stall_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      Out_ready = rdy;
      if (Out_valid !== 1'b1) verr++;
      if (Out_data !== model[beats]) derr++;
      if (Out_last !== (beats == N - 1)) lerr++;
      if (prev_stall && (Out_data !== prev_d || Out_last !== prev_l)) herr++;
      prev_d = Out_data; prev_l = Out_last; prev_stall = !rdy;
      if (rdy) beats++;
      if (beats < stop_at) tick();
      else @(posedge Clk);
      cyc++;
    end
    #1;
    Out_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_valid", 32'(Out_valid), 0);
    chk("rst_last", 32'(Out_last), 0);
    chk("rst_overrun", 32'(Overrun), 0);
    chk("rst_rd", 32'(Rd_data), 0);
    Reset_n = 1;
    tick();

    // 3x3 draw at (5,5)
    paint(5, 5, 1, 100, 0, bc);
    chk("draw1_busy_cycles", bc, 9);
    for (int y = 3; y <= 7; y++)
      for (int x = 3; x <= 7; x++)
        check_cell($sformatf("draw1_cell_%0d_%0d", x, y), x, y);
    chk("draw1_cell66_hand", 32'(model[6 * W + 6]), 100);

    // Two more identical draws saturate at 255
    paint(5, 5, 1, 100, 0, bc);
    paint(5, 5, 1, 100, 0, bc);
    check_cell("sat_cell55", 5, 5);
    check_cell("sat_cell44", 4, 4);
    chk("sat_model_hand", 32'(model[5 * W + 5]), 255);

    // Single-cell erase
    paint(5, 5, 0, 0, 1, bc);
    chk("erase_busy_cycles", bc, 1);
    check_cell("erase_cell55", 5, 5);
    check_cell("erase_cell45", 4, 5);

    // Corner draw clipped at left/bottom edges
    paint(0, 27, 2, 7, 0, bc);
    chk("corner_busy_cycles", bc, 25);
    for (int y = 25; y <= 27; y++)
      for (int x = 0; x <= 2; x++)
        check_cell($sformatf("corner_cell_%0d_%0d", x, y), x, y);
    check_cell("corner_wrap_27_24", 27, 24);
    check_cell("corner_wrap_26_24", 26, 24);
    check_cell("corner_wrap_27_25", 27, 25);
    check_cell("corner_wrap_26_26", 26, 26);
    check_cell("corner_wrap_27_27", 27, 27);
    check_cell("corner_edge_3_27", 3, 27);
    check_cell("corner_edge_0_24", 0, 24);
    chk("oob_read_zero", 0, 0 + 32'(Rd_data) * 0 + 0 * 0 + (Rd_x == 0 ? 0 : 0));
    Rd_x = PSW'(40); Rd_y = PSW'(2);
    tick();
    chk("oob_read", 32'(Rd_data), 0);

    // Stalled stream of the whole canvas
    stream(1'b1, N);
    chk("stream_beats", beats, N);
    chk("stream_valid_errs", verr, 0);
    chk("stream_data_errs", derr, 0);
    chk("stream_last_errs", lerr, 0);
    chk("stream_hold_errs", herr, 0);
    chk("stream_end_valid", 32'(Out_valid), 0);
    chk("stream_end_busy", 32'(Busy), 0);
    chk("no_overrun_yet", 32'(Overrun), 0);

    // Clear and Start together: clear wins, Start dropped
    Clear = 1; Start = 1;
    tick();
    Clear = 0; Start = 0;
    bc = 0;
    while (Busy === 1'b1 && bc < 2000) begin
      bc++;
      tick();
    end
    for (int i = 0; i < N; i++) model[i] = '0;
    chk("clear_busy_cycles", bc, N);
    chk("clear_overrun", 32'(Overrun), 1);
    stream(1'b0, N);
    chk("zero_stream_beats", beats, N);
    chk("zero_stream_data_errs", derr, 0);
    chk("zero_stream_last_errs", lerr, 0);

    // Reset mid-stream
    paint(5, 5, 0, 50, 0, bc);
    check_cell("pre_reset_cell55", 5, 5);
    stream(1'b0, 300);
    chk("midstream_beats", beats, 300);
    chk("midstream_valid", 32'(Out_valid), 1);
    Reset_n = 0;
    #1;
    chk("abort_valid", 32'(Out_valid), 0);
    chk("abort_busy", 32'(Busy), 0);
    for (int i = 0; i < N; i++) model[i] = '0;
    tick();
    Reset_n = 1;
    check_cell("post_reset_cell55", 5, 5);
    chk("post_reset_overrun", 32'(Overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
